reg_file_gen: RTL and testbench



---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_gen_scoreboard.sv | 53 +++++
 rtl/reg_file_gen.sv | 115 +++++++++++
 tb/tb_reg_file_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the generic register file and its pending scoreboard.
package reg_file_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;
   localparam int ZERO_ADDR  = 0;

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

   function automatic int depth(input int addr_w);
      return 2 ** addr_w;
   endfunction

endpackage

// File: rtl/reg_file_gen_scoreboard.sv
// Per-register pending bits: set by a reserve, cleared by any committed write,
// with the reserve winning when both hit the same register in one cycle.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 0
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     write_a,
   input  logic [ADDR_W-1:0]        addr_a,
   input  logic                     write_b,
   input  logic [ADDR_W-1:0]        addr_b,
   input  logic                     reserve,
   input  logic [ADDR_W-1:0]        res_addr,
   output logic [(2**ADDR_W)-1:0]   pending,
   output logic                     any_pending
);

   localparam int DEPTH = depth(ADDR_W);

   logic [DEPTH-1:0] pending_reg;
   logic [DEPTH-1:0] pending_next;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic set_bit;
         logic clr_bit;
         assign set_bit = reserve && (res_addr == ADDR_W'(gi));
         assign clr_bit = (write_a && (addr_a == ADDR_W'(gi))) ||
                          (write_b && (addr_b == ADDR_W'(gi)));
         // A hardwired-zero entry can never have a producer in flight.
         if ((ZERO_REG != 0) && (gi == ZERO_ADDR)) begin : g_zero
            assign pending_next[gi] = 1'b0;
         end else begin : g_normal
            assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign pending     = pending_reg;
   assign any_pending = |pending_reg;

endmodule

// File: rtl/reg_file_gen.sv
// Two-write, two-read register file with pending scoreboard and optional zero register.
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_gen
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              WRITE,
   input  logic [DATA_W-1:0] IN2,
   input  logic [ADDR_W-1:0] IN2ADDRESS,
   input  logic              WRITE2,
   input  logic              RESERVE,
   input  logic [ADDR_W-1:0] RESADDRESS,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   output logic              OUT1_READY,
   output logic              OUT2_READY,
   output logic              ANY_PENDING
);

   localparam int DEPTH = depth(ADDR_W);

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0]  hit_a;
   logic [DEPTH-1:0]  hit_b;
   logic [DEPTH-1:0]  pending;
   logic [1:0][DATA_W-1:0] rd_data;
   logic [1:0]        rd_ready;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
         if ((ZERO_REG != 0) && (gi == ZERO_ADDR)) begin : g_zero
            assign hit_a[gi] = 1'b0;
            assign hit_b[gi] = 1'b0;
         end else begin : g_normal
            assign hit_a[gi] = WRITE  && (INADDRESS  == ADDR_W'(gi));
            assign hit_b[gi] = WRITE2 && (IN2ADDRESS == ADDR_W'(gi));
         end
      end
   endgenerate

   // Port A takes priority when both ports target the same entry.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (RESET) begin
            mem_reg[i] <= '0;
         end else if (hit_a[i]) begin
            mem_reg[i] <= IN;
         end else if (hit_b[i]) begin
            mem_reg[i] <= IN2;
         end
      end
   end

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .CLK         (CLK),
      .RESET       (RESET),
      .write_a     (WRITE),
      .addr_a      (INADDRESS),
      .write_b     (WRITE2),
      .addr_b      (IN2ADDRESS),
      .reserve     (RESERVE && !((ZERO_REG != 0) && (RESADDRESS == ADDR_W'(ZERO_ADDR)))),
      .res_addr    (RESADDRESS),
      .pending     (pending),
      .any_pending (ANY_PENDING)
   );

   generate
      for (genvar pi = 0; pi < 2; pi++) begin : g_read
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data;
         logic              ready;

         assign addr = (pi == 0) ? OUT1ADDRESS : OUT2ADDRESS;

         always_comb begin
            data  = mem_reg[addr];
            ready = ~pending[addr];
            if ((ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR))) begin
               data  = '0;
               ready = 1'b1;
            end
`ifdef REG_FILE_BYPASS_EN
            else if (!RESET && WRITE && (INADDRESS == addr)) begin
               data  = IN;
               ready = 1'b1;
            end else if (!RESET && WRITE2 && (IN2ADDRESS == addr)) begin
               data  = IN2;
               ready = 1'b1;
            end
`endif
         end

         assign rd_data[pi]  = data;
         assign rd_ready[pi] = ready;
      end
   endgenerate

   assign OUT1       = rd_data[0];
   assign OUT2       = rd_data[1];
   assign OUT1_READY = rd_ready[0];
   assign OUT2_READY = rd_ready[1];

endmodule

// File: tb/tb_reg_file_gen.sv
// Table-driven bench for reg_file_gen with an expected-result queue; also covers
// the zero-register variant and REG_FILE_BYPASS_EN forwarding when that macro is defined.
module tb_reg_file_gen;

   logic       CLK;
   logic       RESET;
   logic [7:0] IN, IN2;
   logic [2:0] INADDRESS, IN2ADDRESS, RESADDRESS, OUT1ADDRESS, OUT2ADDRESS;
   logic       WRITE, WRITE2, RESERVE;
   logic [7:0] OUT1, OUT2, Z_OUT1, Z_OUT2;
   logic       OUT1_READY, OUT2_READY, ANY_PENDING;
   logic       Z_OUT1_READY, Z_OUT2_READY, Z_ANY_PENDING;

   int checks   = 0;
   int failures = 0;

   reg_file_gen #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (
      .CLK(CLK), .RESET(RESET),
      .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .IN2(IN2), .IN2ADDRESS(IN2ADDRESS), .WRITE2(WRITE2),
      .RESERVE(RESERVE), .RESADDRESS(RESADDRESS),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
      .OUT1(OUT1), .OUT2(OUT2),
      .OUT1_READY(OUT1_READY), .OUT2_READY(OUT2_READY),
      .ANY_PENDING(ANY_PENDING)
   );

   reg_file_gen #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
      .CLK(CLK), .RESET(RESET),
      .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .IN2(IN2), .IN2ADDRESS(IN2ADDRESS), .WRITE2(WRITE2),
      .RESERVE(RESERVE), .RESADDRESS(RESADDRESS),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
      .OUT1(Z_OUT1), .OUT2(Z_OUT2),
      .OUT1_READY(Z_OUT1_READY), .OUT2_READY(Z_OUT2_READY),
      .ANY_PENDING(Z_ANY_PENDING)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       rst;
      logic       wa;  logic [2:0] aa; logic [7:0] da;
      logic       wb;  logic [2:0] ab; logic [7:0] db;
      logic       rs;  logic [2:0] ra;
      logic [2:0] r1;  logic [2:0] r2;
      logic [7:0] e1;  logic [7:0] e2;
      logic       er1; logic er2; logic eany;
   } vec_t;

   typedef struct {
      int         idx;
      logic [7:0] e1, e2;
      logic       er1, er2, eany;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   function automatic vec_t mk(logic rst, logic wa, logic [2:0] aa, logic [7:0] da,
                               logic wb, logic [2:0] ab, logic [7:0] db,
                               logic rs, logic [2:0] ra, logic [2:0] r1, logic [2:0] r2,
                               logic [7:0] e1, logic [7:0] e2,
                               logic er1, logic er2, logic eany);
      vec_t v;
      v.rst = rst; v.wa = wa; v.aa = aa; v.da = da;
      v.wb = wb; v.ab = ab; v.db = db; v.rs = rs; v.ra = ra;
      v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2;
      v.er1 = er1; v.er2 = er2; v.eany = eany;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      RESET = 1'b0; WRITE = 1'b0; WRITE2 = 1'b0; RESERVE = 1'b0;
      IN = '0; IN2 = '0; INADDRESS = '0; IN2ADDRESS = '0; RESADDRESS = '0;
   endtask

   initial begin
      exp_t e;
      idle_inputs();
      OUT1ADDRESS = '0; OUT2ADDRESS = '0;

      //            rst wa aa  da     wb ab  db     rs ra  r1 r2  e1     e2     r1 r2 any
      vecs.push_back(mk(1, 1, 1, 8'h99, 1, 2, 8'h98, 1, 3, 0, 7, 8'h00, 8'h00, 1, 1, 0));
      for (int a = 0; a < 8; a++)
         vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3'(a), 3'(7 - a), 8'h00, 8'h00, 1, 1, 0));
      vecs.push_back(mk(0, 1, 3, 8'hA5, 1, 5, 8'h3C, 0, 0, 3, 5, 8'hA5, 8'h3C, 1, 1, 0));
      vecs.push_back(mk(0, 1, 2, 8'h11, 1, 2, 8'h22, 0, 0, 2, 3, 8'h11, 8'hA5, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 4, 2, 8'h00, 8'h11, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 4, 8'h7E, 0, 0, 4, 5, 8'h7E, 8'h3C, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4, 8'h99, 0, 0, 8'h00, 1, 4, 4, 4, 8'h99, 8'h99, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 4, 8'h55, 0, 0, 4, 3, 8'h55, 8'hA5, 1, 1, 0));
      vecs.push_back(mk(0, 1, 1, 8'hC3, 1, 6, 8'hD2, 1, 7, 1, 6, 8'hC3, 8'hD2, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 7, 0, 8'h00, 8'h00, 0, 0, 1));
      vecs.push_back(mk(1, 1, 1, 8'h77, 0, 0, 8'h00, 1, 2, 1, 6, 8'h00, 8'h00, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 7, 2, 8'h00, 8'h00, 1, 1, 0));
      vecs.push_back(mk(0, 1, 6, 8'h0F, 0, 0, 8'h00, 0, 0, 6, 7, 8'h0F, 8'h00, 1, 1, 0));

      foreach (vecs[i]) begin
         @(negedge CLK);
         RESET = vecs[i].rst;
         WRITE = vecs[i].wa; INADDRESS = vecs[i].aa; IN = vecs[i].da;
         WRITE2 = vecs[i].wb; IN2ADDRESS = vecs[i].ab; IN2 = vecs[i].db;
         RESERVE = vecs[i].rs; RESADDRESS = vecs[i].ra;
         e.idx = i; e.e1 = vecs[i].e1; e.e2 = vecs[i].e2;
         e.er1 = vecs[i].er1; e.er2 = vecs[i].er2; e.eany = vecs[i].eany;
         exp_q.push_back(e);
         @(posedge CLK);
         #1;
         idle_inputs();
         OUT1ADDRESS = vecs[i].r1; OUT2ADDRESS = vecs[i].r2;
         #1;
         e = exp_q.pop_front();
         $display("vec %0d: rd %0d/%0d -> out1=%0h out2=%0h rdy=%b%b any=%b",
                  e.idx, OUT1ADDRESS, OUT2ADDRESS, OUT1, OUT2, OUT1_READY, OUT2_READY, ANY_PENDING);
         chk($sformatf("v%0d_out1", e.idx), OUT1, e.e1);
         chk($sformatf("v%0d_out2", e.idx), OUT2, e.e2);
         chk($sformatf("v%0d_rdy1", e.idx), {7'd0, OUT1_READY}, {7'd0, e.er1});
         chk($sformatf("v%0d_rdy2", e.idx), {7'd0, OUT2_READY}, {7'd0, e.er2});
         chk($sformatf("v%0d_any", e.idx), {7'd0, ANY_PENDING}, {7'd0, e.eany});
      end

      // Same-cycle read of a register being written (address 6 currently holds 0F).
      @(negedge CLK);
      WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h5A;
      WRITE2 = 1'b1; IN2ADDRESS = 3'd6; IN2 = 8'h66;
      OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd6;
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("bypass_same_cycle", OUT1, 8'h5A);
`else
      chk("no_bypass_old_value", OUT1, 8'h0F);
`endif
      chk("bypass_rdy", {7'd0, OUT1_READY}, 8'd1);
      $display("bypass: same-cycle out1=%0h", OUT1);
      @(posedge CLK);
      #1;
      idle_inputs();
      #1;
      chk("bypass_next_cycle", OUT1, 8'h5A);
      $display("bypass: next-cycle out1=%0h", OUT1);

      // Write and reserve address 0 on both variants together.
      @(negedge CLK);
      WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hFF;
      RESERVE = 1'b1; RESADDRESS = 3'd0;
      OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd6;
      #1;
      chk("zero_same_cycle", Z_OUT1, 8'h00);
      chk("zero_same_cycle_rdy", {7'd0, Z_OUT1_READY}, 8'd1);
      @(posedge CLK);
      #1;
      idle_inputs();
      #1;
      $display("zero: z_out1=%0h z_rdy=%b z_any=%b out1=%0h rdy=%b any=%b",
               Z_OUT1, Z_OUT1_READY, Z_ANY_PENDING, OUT1, OUT1_READY, ANY_PENDING);
      chk("zero_out1", Z_OUT1, 8'h00);
      chk("zero_rdy1", {7'd0, Z_OUT1_READY}, 8'd1);
      chk("zero_any", {7'd0, Z_ANY_PENDING}, 8'd0);
      chk("zero_other_reg", Z_OUT2, 8'h5A);
      chk("nz_addr0_out1", OUT1, 8'hFF);
      chk("nz_addr0_rdy1", {7'd0, OUT1_READY}, 8'd0);
      chk("nz_addr0_any", {7'd0, ANY_PENDING}, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
